// File: rtl/tx_pkg.sv
// Shared constants for the transmit signal generator: LFSR seeds and taps, carrier sign table, FSM encoding.
// The GUARD state exists only when TX_GUARD_EN is defined.
package tx_pkg;

    localparam int LFSR_W      = 10;
    localparam int LFSR_TAP_HI = 9;
    localparam int LFSR_TAP_LO = 6;

    // SEED[k] = {k, 6'b000001}; bit 0 is always set, so no seed is zero.
    localparam logic [LFSR_W-1:0] SEED [16] = '{
        10'h001, 10'h041, 10'h081, 10'h0C1, 10'h101, 10'h141, 10'h181, 10'h1C1,
        10'h201, 10'h241, 10'h281, 10'h2C1, 10'h301, 10'h341, 10'h381, 10'h3C1
    };

    typedef enum logic [1:0] {
        SGN_ZERO = 2'd0,
        SGN_POS  = 2'd1,
        SGN_NEG  = 2'd2
    } carrier_sign_e;

    localparam carrier_sign_e CARRIER_SIGN [4] = '{SGN_ZERO, SGN_POS, SGN_ZERO, SGN_NEG};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
`ifdef TX_GUARD_EN
        S_GUARD = 2'd2,
`endif
        S_DONE  = 2'd3
    } tx_state_e;

    function automatic logic signed [15:0] bpsk_sample(
        input logic [1:0]          phase,
        input logic                chip,
        input logic signed [15:0]  amp
    );
        logic signed [15:0] v;
        v = 16'sd0;
        case (CARRIER_SIGN[phase])
            SGN_POS: v = chip ? amp : -amp;
            SGN_NEG: v = chip ? -amp : amp;
            default: v = 16'sd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/tx_prbs_lfsr.sv
// 10-bit Fibonacci PRBS generator (x^10 + x^7 + 1) with seed load and single-step advance.
module tx_prbs_lfsr
    import tx_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic [LFSR_W-1:0] i_seed,
    input  logic              i_adv,
    output logic              o_chip
);

    logic [LFSR_W-1:0] r_lfsr;

    // Shift register: clear has priority over load, load over advance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr <= {LFSR_W{1'b0}};
        end else if (i_clr) begin
            r_lfsr <= {LFSR_W{1'b0}};
        end else if (i_load) begin
            r_lfsr <= i_seed;
        end else if (i_adv) begin
            r_lfsr <= {r_lfsr[LFSR_W-2:0], r_lfsr[LFSR_TAP_HI] ^ r_lfsr[LFSR_TAP_LO]};
        end else begin
            r_lfsr <= r_lfsr;
        end
    end

    assign o_chip = r_lfsr[0];

endmodule

// File: rtl/tx_signal_generator.sv
// BPSK PRBS transmit generator: fs/4 carrier modulated by one of 16 seeded sequences, one sample per SAMPLE_DIV clocks.
// Optional trailing zero guard samples are built in when TX_GUARD_EN is defined.
module tx_signal_generator
    import tx_pkg::*;
#(
    parameter int SAMPLE_DIV       = 128,
    parameter int SAMPLES_PER_CHIP = 8,
    parameter int CHIP_LEN         = 1023,
    parameter int AMP              = 16384,
    parameter int GUARD_SAMPLES    = 64
) (
    input  logic        ctx_clk,
    input  logic        rtx_rst,
    input  logic        etx_en,
    input  logic        istart,
    input  logic [3:0]  iseq_sel,
    output logic [15:0] otx_sample,
    output logic        otx_sample_valid,
    output logic        otx_signal_trigg,
    output logic        otx_busy,
    output logic        otx_done,
    output logic [3:0]  otx_seq
);

    localparam int DIV_W  = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam int SPC_W  = $clog2(SAMPLES_PER_CHIP);
    localparam int CHIP_W = (CHIP_LEN > 1) ? $clog2(CHIP_LEN) : 1;
    localparam logic signed [15:0] AMP16 = 16'(AMP);

    tx_state_e              r_state, w_state_nx;
    logic [DIV_W-1:0]       r_div, w_div_nx;
    logic [1:0]             r_phase, w_phase_nx;
    logic [SPC_W-1:0]       r_spc, w_spc_nx;
    logic [CHIP_W-1:0]      r_chip, w_chip_nx;
    logic                   r_last, w_last_nx;
    logic signed [15:0]     r_sample, w_sample_nx;
    logic                   r_valid, w_valid_nx;
    logic                   r_trigg, w_trigg_nx;
    logic                   r_busy, w_busy_nx;
    logic                   r_done, w_done_nx;
    logic [3:0]             r_seq, w_seq_nx;
    logic                   w_accept, w_adv, w_slot, w_lfsr_chip;
`ifdef TX_GUARD_EN
    localparam int GUARD_W = (GUARD_SAMPLES < 1) ? 1 : $clog2(GUARD_SAMPLES + 1);
    logic [GUARD_W-1:0]     r_guard, w_guard_nx;
`endif

    tx_prbs_lfsr u_prbs (
        .i_clk   (ctx_clk),
        .i_rst_n (rtx_rst),
        .i_clr   (~etx_en),
        .i_load  (w_accept),
        .i_seed  (SEED[iseq_sel]),
        .i_adv   (w_adv),
        .o_chip  (w_lfsr_chip)
    );

    // Next-state and next-output logic; disable forces everything back to the reset picture.
    always_comb begin
        w_state_nx  = r_state;
        w_div_nx    = r_div;
        w_phase_nx  = r_phase;
        w_spc_nx    = r_spc;
        w_chip_nx   = r_chip;
        w_last_nx   = r_last;
`ifdef TX_GUARD_EN
        w_guard_nx  = r_guard;
`endif
        w_sample_nx = r_sample;
        w_valid_nx  = 1'b0;
        w_trigg_nx  = 1'b0;
        w_busy_nx   = r_busy;
        w_done_nx   = 1'b0;
        w_seq_nx    = r_seq;
        w_accept    = 1'b0;
        w_adv       = 1'b0;
        w_slot      = (r_div == DIV_W'(SAMPLE_DIV - 1));

        if (!etx_en) begin
            w_state_nx  = S_IDLE;
            w_div_nx    = {DIV_W{1'b0}};
            w_phase_nx  = 2'd0;
            w_spc_nx    = {SPC_W{1'b0}};
            w_chip_nx   = {CHIP_W{1'b0}};
            w_last_nx   = 1'b0;
`ifdef TX_GUARD_EN
            w_guard_nx  = {GUARD_W{1'b0}};
`endif
            w_sample_nx = 16'sd0;
            w_busy_nx   = 1'b0;
            w_seq_nx    = 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_sample_nx = 16'sd0;
                    if (istart) begin
                        // The first sample leaves on the acceptance edge, so the seed's chip is used directly.
                        w_accept    = 1'b1;
                        w_state_nx  = S_RUN;
                        w_seq_nx    = iseq_sel;
                        w_div_nx    = {DIV_W{1'b0}};
                        w_phase_nx  = 2'd1;
                        w_spc_nx    = SPC_W'(1);
                        w_chip_nx   = {CHIP_W{1'b0}};
                        w_last_nx   = 1'b0;
                        w_sample_nx = bpsk_sample(2'd0, SEED[iseq_sel][0], AMP16);
                        w_valid_nx  = 1'b1;
                        w_trigg_nx  = 1'b1;
                        w_busy_nx   = 1'b1;
                    end else begin
                        w_busy_nx   = 1'b0;
                    end
                end
                S_RUN: begin
                    if (!w_slot) begin
                        w_div_nx = r_div + DIV_W'(1);
                    end else if (!r_last) begin
                        w_div_nx    = {DIV_W{1'b0}};
                        w_valid_nx  = 1'b1;
                        w_sample_nx = bpsk_sample(r_phase, w_lfsr_chip, AMP16);
                        w_phase_nx  = r_phase + 2'd1;
                        if (r_spc == SPC_W'(SAMPLES_PER_CHIP - 1)) begin
                            w_spc_nx = {SPC_W{1'b0}};
                            w_adv    = 1'b1;
                            if (r_chip == CHIP_W'(CHIP_LEN - 1)) begin
                                w_chip_nx = {CHIP_W{1'b0}};
                                w_last_nx = 1'b1;
                            end else begin
                                w_chip_nx = r_chip + CHIP_W'(1);
                            end
                        end else begin
                            w_spc_nx = r_spc + SPC_W'(1);
                        end
                    end else begin
                        w_div_nx = {DIV_W{1'b0}};
`ifdef TX_GUARD_EN
                        if (GUARD_SAMPLES > 0) begin
                            w_state_nx  = S_GUARD;
                            w_valid_nx  = 1'b1;
                            w_sample_nx = 16'sd0;
                            w_guard_nx  = GUARD_W'(1);
                        end else begin
                            w_state_nx  = S_DONE;
                            w_done_nx   = 1'b1;
                            w_busy_nx   = 1'b0;
                            w_sample_nx = 16'sd0;
                        end
`else
                        w_state_nx  = S_DONE;
                        w_done_nx   = 1'b1;
                        w_busy_nx   = 1'b0;
                        w_sample_nx = 16'sd0;
`endif
                    end
                end
`ifdef TX_GUARD_EN
                S_GUARD: begin
                    if (!w_slot) begin
                        w_div_nx = r_div + DIV_W'(1);
                    end else if (r_guard == GUARD_W'(GUARD_SAMPLES)) begin
                        w_div_nx    = {DIV_W{1'b0}};
                        w_state_nx  = S_DONE;
                        w_done_nx   = 1'b1;
                        w_busy_nx   = 1'b0;
                        w_sample_nx = 16'sd0;
                    end else begin
                        w_div_nx    = {DIV_W{1'b0}};
                        w_valid_nx  = 1'b1;
                        w_sample_nx = 16'sd0;
                        w_guard_nx  = r_guard + GUARD_W'(1);
                    end
                end
`endif
                S_DONE: begin
                    w_state_nx  = S_IDLE;
                    w_sample_nx = 16'sd0;
                    w_busy_nx   = 1'b0;
                end
                default: begin
                    w_state_nx  = S_IDLE;
                    w_sample_nx = 16'sd0;
                    w_busy_nx   = 1'b0;
                end
            endcase
        end
    end

    // State, counter and output registers.
    always_ff @(posedge ctx_clk or negedge rtx_rst) begin
        if (!rtx_rst) begin
            r_state  <= S_IDLE;
            r_div    <= {DIV_W{1'b0}};
            r_phase  <= 2'd0;
            r_spc    <= {SPC_W{1'b0}};
            r_chip   <= {CHIP_W{1'b0}};
            r_last   <= 1'b0;
`ifdef TX_GUARD_EN
            r_guard  <= {GUARD_W{1'b0}};
`endif
            r_sample <= 16'sd0;
            r_valid  <= 1'b0;
            r_trigg  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_seq    <= 4'd0;
        end else begin
            r_state  <= w_state_nx;
            r_div    <= w_div_nx;
            r_phase  <= w_phase_nx;
            r_spc    <= w_spc_nx;
            r_chip   <= w_chip_nx;
            r_last   <= w_last_nx;
`ifdef TX_GUARD_EN
            r_guard  <= w_guard_nx;
`endif
            r_sample <= w_sample_nx;
            r_valid  <= w_valid_nx;
            r_trigg  <= w_trigg_nx;
            r_busy   <= w_busy_nx;
            r_done   <= w_done_nx;
            r_seq    <= w_seq_nx;
        end
    end

    assign otx_sample       = r_sample;
    assign otx_sample_valid = r_valid;
    assign otx_signal_trigg = r_trigg;
    assign otx_busy         = r_busy;
    assign otx_done         = r_done;
    assign otx_seq          = r_seq;

endmodule

// File: tb/tb_tx_signal_generator.sv
// Bench for tx_signal_generator: a short-sequence instance for timing/table/random checks and a long one for LFSR period.
module tb_tx_signal_generator;

    localparam int M_DIV = 4, M_SPC = 8, M_LEN = 5, M_AMP = 16384, GUARD = 3;
    localparam int L_DIV = 2, L_SPC = 4, L_LEN = 1030, L_AMP = 1000;
`ifdef TX_GUARD_EN
    localparam int EXP_GUARD = GUARD;
`else
    localparam int EXP_GUARD = 0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
    logic m_start = 1'b0, l_start = 1'b0;
    logic [3:0] m_sel = 4'd0, l_sel = 4'd0;
    logic [15:0] m_sample, l_sample;
    logic m_valid, m_trigg, m_busy, m_done, l_valid, l_trigg, l_busy, l_done;
    logic [3:0] m_seq, l_seq;

    int checks = 0, failures = 0, cyc = 0;
    int exp_q[$];

    tx_signal_generator #(.SAMPLE_DIV(M_DIV), .SAMPLES_PER_CHIP(M_SPC), .CHIP_LEN(M_LEN),
                          .AMP(M_AMP), .GUARD_SAMPLES(GUARD)) u_dut (
        .ctx_clk(clk), .rtx_rst(rst_n), .etx_en(en), .istart(m_start), .iseq_sel(m_sel),
        .otx_sample(m_sample), .otx_sample_valid(m_valid), .otx_signal_trigg(m_trigg),
        .otx_busy(m_busy), .otx_done(m_done), .otx_seq(m_seq));

    tx_signal_generator #(.SAMPLE_DIV(L_DIV), .SAMPLES_PER_CHIP(L_SPC), .CHIP_LEN(L_LEN),
                          .AMP(L_AMP), .GUARD_SAMPLES(GUARD)) u_long (
        .ctx_clk(clk), .rtx_rst(rst_n), .etx_en(en), .istart(l_start), .iseq_sel(l_sel),
        .otx_sample(l_sample), .otx_sample_valid(l_valid), .otx_signal_trigg(l_trigg),
        .otx_busy(l_busy), .otx_done(l_done), .otx_seq(l_seq));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitors sample on the falling edge.
    int m_q[$], m_cq[$], m_trig_cyc[$];
    int m_done_cnt = 0, m_done_cyc = 0, m_busy_err = 0, m_hold_err = 0, m_busy_seen = 0;
    logic [15:0] m_prev = 16'd0;
    always @(negedge clk) begin
        if (m_valid) begin
            m_q.push_back(int'($signed(m_sample)));
            m_cq.push_back(cyc);
            if (!m_busy) m_busy_err++;
        end else if (m_busy && m_sample !== m_prev) begin
            m_hold_err++;
        end
        if (m_trigg) m_trig_cyc.push_back(cyc);
        if (m_done) begin
            m_done_cnt++;
            m_done_cyc = cyc;
            if (m_busy) m_busy_err++;
        end
        if (m_busy) m_busy_seen++;
        m_prev = m_sample;
    end

    int l_q[$];
    int l_done_cnt = 0;
    always @(negedge clk) begin
        if (l_valid) l_q.push_back(int'($signed(l_sample)));
        if (l_done) l_done_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: chip sequence from the polynomial rule, carrier from the 4-phase table, then guard zeros.
    task automatic build_exp(input int sel, input int spc, input int len, input int amp, input int nguard);
        int l, ph, base;
        exp_q.delete();
        l = (sel << 6) | 1;
        for (int c = 0; c < len; c++) begin
            for (int s = 0; s < spc; s++) begin
                ph = (c * spc + s) % 4;
                base = (ph == 1) ? amp : ((ph == 3) ? -amp : 0);
                exp_q.push_back(((l & 1) == 1) ? base : -base);
            end
            l = ((l << 1) & 'h3FF) | (((l >> 9) ^ (l >> 6)) & 1);
        end
        for (int g = 0; g < nguard; g++) exp_q.push_back(0);
    endtask

    task automatic clear_mon();
        m_q.delete(); m_cq.delete(); m_trig_cyc.delete();
        m_done_cnt = 0; m_done_cyc = 0; m_busy_err = 0; m_hold_err = 0; m_busy_seen = 0;
    endtask

    task automatic run_main(input logic [3:0] sel, input int poke_at, input string tag);
        int start_cyc, n_exp, bad, sp_err, first_bad;
        clear_mon();
        build_exp(int'(sel), M_SPC, M_LEN, M_AMP, EXP_GUARD);
        n_exp = exp_q.size();
        @(negedge clk);
        m_sel = sel; m_start = 1'b1; start_cyc = cyc;
        @(negedge clk);
        m_start = 1'b0; m_sel = ~sel;
        for (int i = 0; i < n_exp * M_DIV + 50 && m_done_cnt == 0; i++) begin
            m_start = (i == poke_at) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        m_start = 1'b0;
        check({tag, " done_seen"}, (m_done_cnt > 0) ? 1 : 0, 1);
        repeat (3) @(negedge clk);
        check({tag, " n_valid"}, m_q.size(), n_exp);
        check({tag, " first_lat"}, (m_cq.size() > 0) ? m_cq[0] - start_cyc : -1, 1);
        check({tag, " n_trigg"}, m_trig_cyc.size(), 1);
        check({tag, " trigg_cyc"}, (m_trig_cyc.size() > 0 && m_cq.size() > 0) ? m_trig_cyc[0] - m_cq[0] : -1, 0);
        bad = 0; sp_err = 0; first_bad = -1;
        for (int i = 0; i < n_exp && i < m_q.size(); i++) begin
            if (m_q[i] != exp_q[i]) begin
                if (first_bad < 0) first_bad = i;
                bad++;
            end
        end
        if (first_bad >= 0)
            check({tag, " first_bad_sample"}, m_q[first_bad], exp_q[first_bad]);
        check({tag, " sample_mismatches"}, bad, 0);
        for (int i = 1; i < m_cq.size(); i++)
            if (m_cq[i] - m_cq[i-1] != M_DIV) sp_err++;
        check({tag, " spacing_err"}, sp_err, 0);
        check({tag, " n_done"}, m_done_cnt, 1);
        check({tag, " done_cyc"}, (m_cq.size() > 0) ? m_done_cyc - m_cq[m_cq.size()-1] : -1, M_DIV);
        check({tag, " busy_err"}, m_busy_err, 0);
        check({tag, " hold_err"}, m_hold_err, 0);
        check({tag, " seq"}, int'(m_seq), int'(sel));
        check({tag, " idle_busy"}, int'(m_busy), 0);
    endtask

    typedef struct {
        logic [3:0] sel;
        int         idx;
        int         exp;
    } vec_t;

    initial begin
        vec_t vecs[8];
        int bad, s, budget;
        logic [3:0] rsel;

        vecs[0] = '{4'd0,  0,      0};
        vecs[1] = '{4'd0,  1,  16384};
        vecs[2] = '{4'd0,  3, -16384};
        vecs[3] = '{4'd0,  9, -16384};
        vecs[4] = '{4'd0, 11,  16384};
        vecs[5] = '{4'd15, 1,  16384};
        vecs[6] = '{4'd15, 9, -16384};
        vecs[7] = '{4'd15, 17, 16384};

        // Reset picture
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({m_sample, m_valid, m_trigg, m_busy, m_done, m_seq}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Start while disabled is ignored
        clear_mon();
        m_sel = 4'd5; m_start = 1'b1;
        @(negedge clk);
        m_start = 1'b0;
        repeat (20) @(negedge clk);
        check("disabled_valids", m_q.size(), 0);
        check("disabled_busy", m_busy_seen, 0);
        en = 1'b1;
        @(negedge clk);

        // Table vectors
        for (int v = 0; v < 8; v++) begin
            run_main(vecs[v].sel, -1, $sformatf("vec%0d", v));
            check($sformatf("vec%0d sample[%0d]", v, vecs[v].idx),
                  (m_q.size() > vecs[v].idx) ? m_q[vecs[v].idx] : 99999, vecs[v].exp);
        end

        // Randomised sequence selection against the model
        for (int r = 0; r < 6; r++) begin
            rsel = 4'($urandom_range(15, 0));
            run_main(rsel, -1, $sformatf("rand%0d_sel%0d", r, rsel));
        end

        // Start while busy is ignored, then a new start after done uses its own sequence
        run_main(4'd3, 20, "busy_poke");
        run_main(4'd9, -1, "restart");

        // Async reset mid-run clears at once, no done
        clear_mon();
        @(negedge clk);
        m_sel = 4'd7; m_start = 1'b1;
        @(negedge clk);
        m_start = 1'b0;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", int'({m_sample, m_valid, m_trigg, m_busy, m_done, m_seq}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_mid_done", m_done_cnt, 0);

        // Enable drop mid-run clears on the next edge, no done
        clear_mon();
        m_sel = 4'd7; m_start = 1'b1;
        @(negedge clk);
        m_start = 1'b0;
        repeat (30) @(negedge clk);
        check("en_mid_busy_before", int'(m_busy), 1);
        en = 1'b0;
        @(negedge clk);
        check("en_mid_outputs", int'({m_sample, m_valid, m_trigg, m_busy, m_done, m_seq}), 0);
        repeat (10) @(negedge clk);
        check("en_mid_done", m_done_cnt, 0);
        en = 1'b1;
        @(negedge clk);

        // Long instance: sel 15 over more than one LFSR period
        l_q.delete(); l_done_cnt = 0;
        build_exp(15, L_SPC, L_LEN, L_AMP, EXP_GUARD);
        l_sel = 4'd15; l_start = 1'b1;
        @(negedge clk);
        l_start = 1'b0; l_sel = 4'd0;
        budget = (L_LEN * L_SPC + EXP_GUARD) * L_DIV + 100;
        for (int i = 0; i < budget && l_done_cnt == 0; i++) @(negedge clk);
        check("long done_seen", l_done_cnt, 1);
        check("long seq", int'(l_seq), 15);
        check("long n_valid", l_q.size(), exp_q.size());
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < l_q.size(); i++)
            if (l_q[i] != exp_q[i]) bad++;
        check("long sample_mismatches", bad, 0);
        bad = 0;
        if (l_q.size() >= L_LEN * L_SPC) begin
            for (int c = 0; c < L_LEN - 1023; c++) begin
                s = l_q[(1023 + c) * L_SPC + 1];
                if (s != l_q[c * L_SPC + 1]) bad++;
            end
        end else begin
            bad = -1;
        end
        check("long period_repeat", bad, 0);
        check("long first_chip_pos", (l_q.size() > 1) ? l_q[1] : 0, L_AMP);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
